// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types for the EX-stage hazard sequencer:
// FSM encodings, the control bundle and the source-match helper.
package ex_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN = 2'd0,
    HZ_LU  = 2'd1,
    HZ_MC  = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_bubble;
    logic redirect_valid;
  } hz_ctl_t;

  function automatic logic src_hit(
    input logic       used,
    input logic [4:0] rs,
    input logic [4:0] rd
  );
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/hz_sat_cnt.sv
// Saturating up-counter used for the stall and flush
// performance counters; sticks at all-ones.
module hz_sat_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard sequencer: stall/flush/bubble controls
// for branch redirect, load-use and multi-cycle EX ops.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int unsigned LU_STALL_CYC = 1,
  parameter int unsigned MC_MAX_CYC   = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_is_jump,
  input  logic [31:0]      ex_npc,
  input  logic             ex_mc_start,
  input  logic             mc_done,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_bubble,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             mc_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int CW = $clog2(MC_MAX_CYC) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] MC_LIM  = CW'(MC_MAX_CYC);
  localparam logic [CW-1:0] LU_LAST = CW'(LU_STALL_CYC - 1);
  localparam logic LU_MULTI = (LU_STALL_CYC > 1);

  hz_state_e     state_q;
  hz_state_e     state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          err_q;
  logic          err_d;

  hz_ctl_t   run_ctl;
  hz_state_e run_nxt;
  hz_ctl_t   ctl;
  logic      mc_en;
  logic      lu_hit;
  logic      mc_go;
  logic      jmp_go;
  logic      lu_go;

  assign lu_hit = ex_is_load && (ex_rd != REG_X0) &&
                  (src_hit(id_rs1_used, id_rs1, ex_rd) ||
                   src_hit(id_rs2_used, id_rs2, ex_rd));

  // mc_start is masked on the MC release cycle.
  assign mc_en  = (state_q == HZ_RUN);
  assign mc_go  = ex_valid && ex_mc_start && mc_en;
  assign jmp_go = ex_valid && ex_is_jump && !mc_go;
  assign lu_go  = ex_valid && lu_hit && !mc_go && !ex_is_jump;

  always_comb begin
    run_ctl = '0;
    run_nxt = HZ_RUN;
    unique case (1'b1)
      mc_go: begin
        run_ctl.pc_stall     = 1'b1;
        run_ctl.ifid_stall   = 1'b1;
        run_ctl.idex_stall   = 1'b1;
        run_ctl.exmem_bubble = 1'b1;
        run_nxt              = HZ_MC;
      end
      jmp_go: begin
        run_ctl.redirect_valid = 1'b1;
        run_ctl.ifid_flush     = 1'b1;
        run_ctl.idex_flush     = 1'b1;
      end
      lu_go: begin
        run_ctl.pc_stall   = 1'b1;
        run_ctl.ifid_stall = 1'b1;
        run_ctl.idex_flush = 1'b1;
        run_nxt            = LU_MULTI ? HZ_LU : HZ_RUN;
      end
      default: ;
    endcase
  end

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      HZ_RUN: begin
        ctl     = run_ctl;
        state_d = run_nxt;
        if (run_nxt != HZ_RUN) begin
          cnt_d = CNT_ONE;
        end
      end
      HZ_LU: begin
        ctl.pc_stall   = 1'b1;
        ctl.ifid_stall = 1'b1;
        ctl.idex_flush = 1'b1;
        cnt_d          = cnt_q + CNT_ONE;
        if (cnt_q == LU_LAST) begin
          state_d = HZ_RUN;
        end
      end
      HZ_MC: begin
        if (mc_done || (cnt_q == MC_LIM)) begin
          ctl     = run_ctl;
          state_d = run_nxt;
          cnt_d   = CNT_ONE;
          if (!mc_done) begin
            err_d = 1'b1;
          end
        end else begin
          ctl.pc_stall     = 1'b1;
          ctl.ifid_stall   = 1'b1;
          ctl.idex_stall   = 1'b1;
          ctl.exmem_bubble = 1'b1;
          cnt_d            = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = HZ_RUN;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign pc_stall       = ctl.pc_stall;
  assign ifid_stall     = ctl.ifid_stall & ~ctl.ifid_flush;
  assign idex_stall     = ctl.idex_stall;
  assign ifid_flush     = ctl.ifid_flush;
  assign idex_flush     = ctl.idex_flush;
  assign exmem_bubble   = ctl.exmem_bubble;
  assign redirect_valid = ctl.redirect_valid;
  assign redirect_pc    = ex_npc;
  assign mc_err         = err_q;

  hz_sat_cnt #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i (cpu_clk),
    .rst_ni(cpu_rst_n),
    .inc_i (pc_stall),
    .cnt_o (stall_cnt)
  );

  hz_sat_cnt #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk_i (cpu_clk),
    .rst_ni(cpu_rst_n),
    .inc_i (redirect_valid),
    .cnt_o (flush_cnt)
  );

endmodule
